// File: rtl/vco_adc_pkg.sv
// Shared types and widths for the VCO ADC capture sequencer.
package vco_adc_pkg;
    localparam int ADC_DW = 32;
    localparam int OVS_W  = 10;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        FLUSH,
        CAPTURE,
        DONE
    } state_e;
endpackage

// File: rtl/vco_adc_capture_ctrl_if.sv
// CPU-side readout port of the capture FIFO.
interface vco_adc_capture_ctrl_if #(
    parameter int DW = 32,
    parameter int LW = 5
);
    logic          rd_en;
    logic [DW-1:0] rd_dat;
    logic          empty;
    logic [LW-1:0] level;

    modport master (output rd_en, input rd_dat, empty, level);
    modport slave  (input rd_en, output rd_dat, empty, level);
endinterface

// File: rtl/vco_adc_fifo.sv
// First-word-fall-through capture FIFO; a pop frees a slot for a push in the same cycle.
module vco_adc_fifo
    import vco_adc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = ADC_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DW-1:0]         push_dat,
    output logic                  full,
    vco_adc_capture_ctrl_if.slave rd
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    always_comb begin
        // level never exceeds DEPTH, so its top bit alone marks full
        full     = level_q[AW];
        do_pop   = rd.rd_en && !empty_q;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr_q] <= push_dat;
    end

    assign rd.rd_dat = empty_q ? '0 : mem[rd_ptr_q];
    assign rd.level  = level_q;
    assign rd.empty  = empty_q;
endmodule

// File: rtl/vco_adc_capture_ctrl.sv
// Capture sequencer: power VCO, settle, flush sinc3, capture N words into the FIFO.
module vco_adc_capture_ctrl
    import vco_adc_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DISCARD    = 3,
    parameter int DW         = ADC_DW
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic [OVS_W-1:0]              cfg_oversample_i,
    input  logic [CNT_W-1:0]              cfg_settle_i,
    input  logic [CNT_W-1:0]              cfg_nsamples_i,
    output logic [OVS_W-1:0]              oversample_o,
    output logic                          sinc_en_o,
    output logic                          vco_enb_o,
    input  logic                          adc_dvalid_i,
    input  logic [DW-1:0]                 adc_dat_i,
    input  logic                          rd_en_i,
    output logic [DW-1:0]                 rd_dat_o,
    output logic                          fifo_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o,
    output logic                          irq_o
);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int DCW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0] nsamp_q, nsamp_d;
    logic [OVS_W-1:0] ovs_q, ovs_d;
    logic [DCW-1:0]   disc_cnt_q, disc_cnt_d;
    logic             done_q, done_d, ovf_q, ovf_d, irq_q, irq_d;
    logic             busy_q, busy_d, vco_enb_q, vco_enb_d, sinc_en_q, sinc_en_d;
    logic             fifo_clr, fifo_push, fifo_full;

    vco_adc_capture_ctrl_if #(.DW(DW), .LW(LW)) rd_if ();

    vco_adc_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clr      (fifo_clr),
        .push     (fifo_push),
        .push_dat (adc_dat_i),
        .full     (fifo_full),
        .rd       (rd_if)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        nsamp_d      = nsamp_q;
        ovs_d        = ovs_q;
        disc_cnt_d   = disc_cnt_q;
        done_d       = done_q;
        ovf_d        = ovf_q;
        fifo_clr     = 1'b0;
        fifo_push    = 1'b0;
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d      = SETTLE;
                settle_cnt_d = cfg_settle_i;
                nsamp_d      = cfg_nsamples_i;
                ovs_d        = cfg_oversample_i;
                done_d       = 1'b0;
                ovf_d        = 1'b0;
                fifo_clr     = 1'b1;
            end
            SETTLE: begin
                if (stop_i) state_d = DONE;
                else if (settle_cnt_q == '0) begin
                    state_d    = FLUSH;
                    disc_cnt_d = '0;
                end else settle_cnt_d = settle_cnt_q - 1'b1;
            end
            FLUSH: begin
                if (stop_i) state_d = DONE;
                else if (adc_dvalid_i) begin
                    if (disc_cnt_q == DCW'(DISCARD - 1)) begin
                        state_d   = CAPTURE;
                        cap_cnt_d = '0;
                    end else disc_cnt_d = disc_cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                // dropped words still count, so a full FIFO cannot stall a finite run
                fifo_push = adc_dvalid_i;
                if (adc_dvalid_i) begin
                    cap_cnt_d = cap_cnt_q + 1'b1;
                    if (nsamp_q != '0 && cap_cnt_d == nsamp_q) state_d = DONE;
                end
                if (stop_i) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (fifo_push && fifo_full && !rd_en_i) ovf_d = 1'b1;
        if (state_d == DONE) done_d = 1'b1;
        irq_d     = (state_d == DONE) && (state_q != DONE);
        busy_d    = state_d inside {SETTLE, FLUSH, CAPTURE};
        vco_enb_d = !busy_d;
        sinc_en_d = state_d inside {FLUSH, CAPTURE};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            cap_cnt_q    <= '0;
            nsamp_q      <= '0;
            ovs_q        <= '0;
            disc_cnt_q   <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            irq_q        <= 1'b0;
            busy_q       <= 1'b0;
            vco_enb_q    <= 1'b1;
            sinc_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            nsamp_q      <= nsamp_d;
            ovs_q        <= ovs_d;
            disc_cnt_q   <= disc_cnt_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            irq_q        <= irq_d;
            busy_q       <= busy_d;
            vco_enb_q    <= vco_enb_d;
            sinc_en_q    <= sinc_en_d;
        end
    end

    assign rd_if.rd_en  = rd_en_i;
    assign rd_dat_o     = rd_if.rd_dat;
    assign fifo_empty_o = rd_if.empty;
    assign fifo_level_o = rd_if.level;
    assign oversample_o = ovs_q;
    assign sinc_en_o    = sinc_en_q;
    assign vco_enb_o    = vco_enb_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign irq_o        = irq_q;
endmodule

// File: tb/tb_vco_adc_capture_ctrl.sv
// Directed + randomized bench for vco_adc_capture_ctrl with a queue-based reference model.
module tb_vco_adc_capture_ctrl;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int LW    = 5;
    localparam int DISC  = 3;

    logic          clk = 1'b0;
    logic          rst, start, stop, dvalid;
    logic [9:0]    ovs, ovs_o;
    logic [15:0]   settle, nsamp;
    logic [DW-1:0] dat;
    logic          sinc_en, vco_enb, busy, done, ovf, irq;

    vco_adc_capture_ctrl_if #(.DW(DW), .LW(LW)) rbus ();

    always #5 clk = ~clk;

    vco_adc_capture_ctrl #(.FIFO_DEPTH(DEPTH), .DISCARD(DISC), .DW(DW)) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .start_i          (start),
        .stop_i           (stop),
        .cfg_oversample_i (ovs),
        .cfg_settle_i     (settle),
        .cfg_nsamples_i   (nsamp),
        .oversample_o     (ovs_o),
        .sinc_en_o        (sinc_en),
        .vco_enb_o        (vco_enb),
        .adc_dvalid_i     (dvalid),
        .adc_dat_i        (dat),
        .rd_en_i          (rbus.rd_en),
        .rd_dat_o         (rbus.rd_dat),
        .fifo_empty_o     (rbus.empty),
        .fifo_level_o     (rbus.level),
        .busy_o           (busy),
        .done_o           (done),
        .overflow_o       (ovf),
        .irq_o            (irq)
    );

    int          checks = 0;
    int          errors = 0;
    int          irq_cnt = 0;
    int          widx;
    logic [31:0] q[$];
    logic        exp_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (irq === 1'b1) irq_cnt++;
    endtask

    // Start a run and check the VCO/sinc power-up timeline.
    task automatic start_run(input int s, input int n, input int o);
        settle = 16'(s); nsamp = 16'(n); ovs = 10'(o);
        start = 1'b1;
        tick();
        start = 1'b0;
        settle = 16'hffff; nsamp = 16'd1; ovs = 10'($urandom);
        q.delete(); exp_ovf = 1'b0; widx = 0; irq_cnt = 0;
        chk("start_vco_enb", vco_enb, 0);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_level", rbus.level, 0);
        chk("start_ovs", ovs_o, 64'(10'(o)));
        for (int i = 0; i < s; i++) tick();
        chk("settle_sinc_off", sinc_en, 0);
        tick();
        chk("flush_sinc_on", sinc_en, 1);
    endtask

    // One ADC word after 'gap' idle cycles, optionally with a same-cycle pop.
    task automatic send(input int gap, input bit rd);
        repeat (gap) tick();
        dvalid = 1'b1; dat = $urandom; rbus.rd_en = rd;
        if (rd && q.size() > 0) begin
            chk("pop_head", rbus.rd_dat, 64'(q[0]));
            void'(q.pop_front());
        end
        if (widx >= DISC) begin
            if (q.size() < DEPTH) q.push_back(dat);
            else exp_ovf = 1'b1;
        end
        widx++;
        tick();
        dvalid = 1'b0; rbus.rd_en = 1'b0;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_vco_enb"}, vco_enb, 1);
        chk({tag, "_sinc_en"}, sinc_en, 0);
        chk({tag, "_irq"}, irq, 1);
        chk({tag, "_level"}, rbus.level, 64'(q.size()));
        chk({tag, "_ovf"}, ovf, 64'(exp_ovf));
        repeat (2) tick();
        chk({tag, "_irq_once"}, irq_cnt, 1);
        chk({tag, "_done_sticky"}, done, 1);
    endtask

    task automatic pop_one();
        chk("rd_dat", rbus.rd_dat, 64'(q[0]));
        void'(q.pop_front());
        rbus.rd_en = 1'b1;
        tick();
        rbus.rd_en = 1'b0;
    endtask

    task automatic drain();
        while (q.size() > 0) pop_one();
        chk("drain_empty", rbus.empty, 1);
        chk("drain_level", rbus.level, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dvalid = 1'b0; dat = '0;
        ovs = '0; settle = '0; nsamp = '0; rbus.rd_en = 1'b0;
        repeat (2) tick();
        chk("rst_vco_enb", vco_enb, 1);
        chk("rst_sinc_en", sinc_en, 0);
        chk("rst_ovs", ovs_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_irq", irq, 0);
        chk("rst_empty", rbus.empty, 1);
        chk("rst_level", rbus.level, 0);
        chk("rst_rd_dat", rbus.rd_dat, 0);
        rst = 1'b0;
        tick();

        // stop and pop while idle have no effect
        stop = 1'b1; rbus.rd_en = 1'b1;
        tick();
        stop = 1'b0; rbus.rd_en = 1'b0;
        chk("idle_stop_busy", busy, 0);
        chk("idle_stop_done", done, 0);
        chk("idle_pop_level", rbus.level, 0);

        // basic run: 3 flushed, 5 captured, dvalid every 8 clocks
        start_run(4, 5, 64);
        repeat (8) send(7, 0);
        check_done("t1");
        dvalid = 1'b1; dat = $urandom;
        tick();
        dvalid = 1'b0;
        chk("t1_no_push_in_done", rbus.level, 5);
        drain();

        // overflow: 20 words into 16 entries, no reads
        start_run(int'($urandom_range(0, 3)), 20, int'($urandom_range(1, 1023)));
        repeat (DISC + 20) send(int'($urandom_range(0, 4)), 0);
        check_done("t2");
        drain();

        // continuous mode terminated by stop
        start_run(0, 0, int'($urandom_range(1, 1023)));
        repeat (DISC + 7) send(int'($urandom_range(0, 3)), 0);
        chk("t3_level", rbus.level, 7);
        chk("t3_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_done("t3");
        drain();

        // simultaneous push/pop at empty and at full; dvalid in the stop cycle
        start_run(2, 0, 100);
        repeat (DISC) send(1, 0);
        send(2, 1);
        chk("t4_empty_pushpop_level", rbus.level, 1);
        chk("t4_empty_pushpop_head", rbus.rd_dat, 64'(q[0]));
        repeat (DEPTH - 1) send(0, 0);
        chk("t4_full_level", rbus.level, DEPTH);
        send(0, 1);
        chk("t4_full_pushpop_level", rbus.level, DEPTH);
        chk("t4_full_pushpop_ovf", ovf, 0);
        pop_one();
        chk("t4_pop_level", rbus.level, DEPTH - 1);
        stop = 1'b1; dvalid = 1'b1; dat = $urandom;
        q.push_back(dat);
        tick();
        stop = 1'b0; dvalid = 1'b0;
        check_done("t4");
        drain();

        // start while busy is ignored; start+stop: start wins idle, stop wins busy
        start_run(1, 4, 200);
        repeat (DISC + 1) send(1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_start_ignored_busy", busy, 1);
        chk("t5_start_ignored_level", rbus.level, 1);
        repeat (3) send(1, 0);
        check_done("t5");
        settle = 16'd3; nsamp = 16'd2;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        q.delete(); exp_ovf = 1'b0; irq_cnt = 0;
        chk("t5_both_idle_busy", busy, 1);
        chk("t5_both_idle_done", done, 0);
        chk("t5_both_idle_level", rbus.level, 0);
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_done("t5b");

        // asynchronous reset mid-capture
        start_run(0, 0, 300);
        repeat (DISC + 3) send(0, 0);
        chk("t6_level", rbus.level, 3);
        rst = 1'b1;
        #2;
        chk("t6_vco_enb", vco_enb, 1);
        chk("t6_sinc_en", sinc_en, 0);
        chk("t6_ovs", ovs_o, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_empty", rbus.empty, 1);
        chk("t6_level_rst", rbus.level, 0);
        chk("t6_rd_dat", rbus.rd_dat, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
